// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the TRS decoder: TRS word constants, bit positions
// of the F/V/H/T flag bus, the lock state type and the XYZ protection check.
// -----------------------------------------------------------------------------
package video_pkg;

    localparam logic [9:0] TRS_PREAMBLE = 10'h3FF;
    localparam logic [9:0] TRS_ZERO     = 10'h000;

    localparam int unsigned F_BIT = 32'd3;
    localparam int unsigned V_BIT = 32'd2;
    localparam int unsigned H_BIT = 32'd1;
    localparam int unsigned T_BIT = 32'd0;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } trs_state_t;

    // Protection bits of an XYZ word: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
    // Bit 9 and bits [1:0] are not part of the protection check.
    function automatic logic xyz_ok(input logic [9:0] xyz);
        logic f;
        logic v;
        logic h;
        logic unused_bits;
        f = xyz[8];
        v = xyz[7];
        h = xyz[6];
        unused_bits = ^{xyz[9], xyz[1:0]};
        return (xyz[5:2] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    endfunction

endpackage

// File: rtl/trs_window.sv
// -----------------------------------------------------------------------------
// trs_window
// Four-word delay line on the 20-bit video stream plus TRS window decode.
// Ports:
//   i_clk, i_n_reset : word clock, async active-low reset
//   i_vdat [19:0]    : incoming raw video word
//   o_colour [19:0]  : oldest word of the delay line (4-cycle delayed data)
//   o_match          : window holds 3FF,000,000,XYZ (XYZ bit9 set)
//   o_valid          : o_match and the XYZ protection bits are correct
//   o_f, o_v, o_h    : F/V/H fields of the XYZ word in the window
// -----------------------------------------------------------------------------
module trs_window
    import video_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_n_reset,
    input  logic [19:0] i_vdat,
    output logic [19:0] o_colour,
    output logic        o_match,
    output logic        o_valid,
    output logic        o_f,
    output logic        o_v,
    output logic        o_h
);

    logic [19:0] s0_q;
    logic [19:0] s1_q;
    logic [19:0] s2_q;
    logic [19:0] s3_q;

    // Shift the word stream; s3 is the oldest word.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            s0_q <= 20'h00000;
            s1_q <= 20'h00000;
            s2_q <= 20'h00000;
            s3_q <= 20'h00000;
        end else begin
            s0_q <= i_vdat;
            s1_q <= s0_q;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Window decode on the TRS-carrying channel only.
    always_comb begin
        o_match = 1'b0;
        o_valid = 1'b0;
        if ((s3_q[9:0] == TRS_PREAMBLE) && (s2_q[9:0] == TRS_ZERO) &&
            (s1_q[9:0] == TRS_ZERO) && s0_q[9]) begin
            o_match = 1'b1;
            o_valid = xyz_ok(s0_q[9:0]);
        end else begin
            o_match = 1'b0;
            o_valid = 1'b0;
        end
    end

    assign o_colour = s3_q;
    assign o_f      = s0_q[8];
    assign o_v      = s0_q[7];
    assign o_h      = s0_q[6];

endmodule

// File: rtl/trs_decoder.sv
// -----------------------------------------------------------------------------
// trs_decoder
// Recovers F/V/H timing from embedded TRS words, tracks lock and counts
// protection errors.
// Ports:
//   i_clk, i_n_reset        : word clock, async active-low reset
//   i_vdat [19:0]           : raw video word ([9:0] carries TRS)
//   o_vdat_colour [19:0]    : i_vdat delayed by 4 cycles
//   o_fvht [3:0]            : F, V blank, H blank, T (TRS word on output)
//   o_locked                : decoder is in LOCKED
//   o_trs_err               : one-cycle pulse per TRS with bad protection
//   o_err_count [ERR_W-1:0] : saturating protection-error count
// -----------------------------------------------------------------------------
module trs_decoder
    import video_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 32'd4,
    parameter int unsigned MAX_GAP    = 32'd4400,
    parameter int unsigned ERR_W      = 32'd8
) (
    input  logic             i_clk,
    input  logic             i_n_reset,
    input  logic [19:0]      i_vdat,
    output logic [19:0]      o_vdat_colour,
    output logic [3:0]       o_fvht,
    output logic             o_locked,
    output logic             o_trs_err,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int unsigned GAP_W  = $clog2(MAX_GAP + 32'd1);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 32'd1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MAX_GAP);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    logic match_s;
    logic valid_s;
    logic xyz_f_s;
    logic xyz_v_s;
    logic xyz_h_s;

    trs_state_t        state_q,   state_d;
    logic              f_q,       f_d;
    logic              v_q,       v_d;
    logic              h_q,       h_d;
    logic [1:0]        t_cnt_q,   t_cnt_d;
    logic [GAP_W-1:0]  gap_q,     gap_d;
    logic [GOOD_W-1:0] good_q,    good_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              trs_err_q, trs_err_d;

    trs_window u_window (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .i_vdat    (i_vdat),
        .o_colour  (o_vdat_colour),
        .o_match   (match_s),
        .o_valid   (valid_s),
        .o_f       (xyz_f_s),
        .o_v       (xyz_v_s),
        .o_h       (xyz_h_s)
    );

    // Next-state for flags, counters and the lock FSM.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        v_d       = v_q;
        h_d       = h_q;
        t_cnt_d   = (t_cnt_q != 2'd0) ? (t_cnt_q - 2'd1) : 2'd0;
        gap_d     = gap_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        trs_err_d = 1'b0;

        // The gap counter restarts on a valid TRS only; a bad TRS is a gap word.
        if (valid_s) begin
            gap_d = {GAP_W{1'b0}};
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end

        if (valid_s) begin
            f_d     = xyz_f_s;
            v_d     = xyz_v_s;
            h_d     = xyz_h_s;
            t_cnt_d = 2'd3;
            if (good_q != GOOD_LOCK) begin
                good_d = good_q + GOOD_W'(1);
            end else begin
                good_d = good_q;
            end
        end else if (match_s) begin
            trs_err_d = 1'b1;
            good_d    = {GOOD_W{1'b0}};
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            good_d = good_q;
        end

        // Transitions use the updated counters so lock changes on the same
        // edge as the event; a valid TRS always wins over the gap limit.
        case (state_q)
            SEARCH: begin
                if (valid_s && (good_d == GOOD_LOCK)) begin
                    state_d = LOCKED;
                end else begin
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                if (match_s && !valid_s) begin
                    state_d = SEARCH;
                end else if (!valid_s && (gap_d == GAP_MAX)) begin
                    state_d = SEARCH;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State, flag and counter registers.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q   <= SEARCH;
            f_q       <= 1'b0;
            v_q       <= 1'b1;
            h_q       <= 1'b1;
            t_cnt_q   <= 2'd0;
            gap_q     <= {GAP_W{1'b0}};
            good_q    <= {GOOD_W{1'b0}};
            err_cnt_q <= {ERR_W{1'b0}};
            trs_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            v_q       <= v_d;
            h_q       <= h_d;
            t_cnt_q   <= t_cnt_d;
            gap_q     <= gap_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
            trs_err_q <= trs_err_d;
        end
    end

    // Flag bus: blanking forced while searching; T covers the matched word
    // (3FF on the output) and the three words that follow it.
    always_comb begin
        o_fvht        = 4'b0110;
        o_fvht[F_BIT] = f_q;
        if (state_q == LOCKED) begin
            o_fvht[V_BIT] = v_q;
            o_fvht[H_BIT] = h_q;
        end else begin
            o_fvht[V_BIT] = 1'b1;
            o_fvht[H_BIT] = 1'b1;
        end
        o_fvht[T_BIT] = valid_s | (t_cnt_q != 2'd0);
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_trs_err   = trs_err_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: doc/trs_decoder.md
# trs_decoder

Recovers video timing from the embedded timing reference sequences (TRS: 3FF, 000, 000, XYZ) in the raw 20-bit video word stream. It emits delay-aligned colour data plus the 4-bit F/V/H/T flag bus (`fvht`). It sits directly upstream of `verticalModifier` and drives its `i_vdat_colour` and `i_fvht` inputs. The block also validates XYZ protection bits, tracks lock, and counts protection errors.

## Interface

Parameters:
- `LOCK_COUNT`, 4: number of consecutive valid TRS required to enter LOCKED.
- `MAX_GAP`, 4400: maximum words between TRS before lock is dropped.
- `ERR_W`, 8: width of the error counter.

Ports:
- `i_clk`, input, 1: video word clock, one word per cycle.
- `i_n_reset`, input, 1: asynchronous, active-low reset.
- `i_vdat`, input, 20: raw video word; [9:0] is the TRS-carrying channel, [19:10] is the second channel.
- `o_vdat_colour`, output, 20: `i_vdat` delayed by exactly 4 cycles; reset 0.
- `o_fvht`, output, 4: [3]=F (field), [2]=V blank, [1]=H blank, [0]=T (TRS word on `o_vdat_colour`); reset 4'b0110.
- `o_locked`, output, 1: high in LOCKED; reset 0.
- `o_trs_err`, output, 1: one-cycle pulse per TRS with a bad protection field; reset 0.
- `o_err_count`, output, ERR_W: saturating protection-error count; reset 0.

## Operation

- **Pipeline.** 4-entry shift register `s0..s3` on the full 20-bit word; `s3` is the oldest. `o_vdat_colour = s3`.
- **Window match.** Combinational test on [9:0]: s3=3FF, s2=000, s1=000, and s0[9]=1.
  - XYZ fields: F=s0[8], V=s0[7], H=s0[6], P3..P0=s0[5:2].
  - Required parity: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H. s0[1:0] are ignored.
- **Valid TRS** (match and parity correct):
  - On that edge, latch the F/V/H registers.
  - Load the 2-bit T counter with 3.
  - Clear the gap counter.
  - Increment the good-TRS counter.
- **Bad TRS** (match but parity wrong):
  - F/V/H hold their values.
  - `o_trs_err` pulses on the next cycle.
  - `o_err_count` increments and saturates at all-ones.
  - Good-TRS counter clears.
  - State goes to SEARCH.
- **No match:** 3FF,000,000 followed by a word with bit9=0 is not a TRS. There is no T flag and no error.
- **T flag.** `o_fvht[0]` = match-valid OR T counter ≠ 0. The T counter decrements to 0 and is high for exactly the 4 cycles `o_vdat_colour` shows the TRS words.
- **State machine:**
  - SEARCH → LOCKED when the good-TRS counter reaches `LOCK_COUNT`.
  - LOCKED → SEARCH on a bad TRS, or when the gap counter reaches `MAX_GAP`.
  - The gap counter increments every cycle without a valid TRS and saturates.
- **Output flags in SEARCH:** `o_fvht[2:1]` are forced to 11 so downstream stages stay blanked; F passes from its register. In LOCKED, the registered F/V/H drive outputs directly.
- **Arithmetic widths:**
  - Gap counter is $clog2(MAX_GAP+1) bits.
  - Good-TRS counter is $clog2(LOCK_COUNT+1) bits and saturates.
- **Reset mid-operation.** Everything returns to its reset values immediately: shift register cleared, SEARCH, F/V/H = 0/1/1. A TRS straddling reset is lost.
- **Simultaneous events.** A valid TRS on the same edge the gap counter hits `MAX_GAP` counts as valid: gap clears, no lock loss.

## Timing

- Data latency is 4 cycles, input edge to `o_vdat_colour`.
- Inputs: the word sampled at edge n appears at edge n+4.
- F/V/H from a valid TRS become visible on `o_fvht[3:1]` from the cycle `o_vdat_colour` shows the first 000 word (2nd TRS word) onward.
- `o_trs_err` and counter updates follow the match cycle by 1.
- `o_locked` rises 1 cycle after the `LOCK_COUNT`-th valid match edge and falls 1 cycle after the loss condition.
- All outputs are registered except `o_fvht[0]` and the SEARCH forcing, which decode from registers only (glitch-free relative to `i_clk`).

## Structure

- **Package `video_pkg`:**
  - Constants: `TRS_PREAMBLE` (10'h3FF), `TRS_ZERO` (10'h000), and FVHT bit indices F_BIT=3, V_BIT=2, H_BIT=1, T_BIT=0.
  - Typedef `trs_state_t` {SEARCH, LOCKED}.
  - Function `xyz_ok(logic [9:0])`.
- **Sub-module `trs_window`:** the 4-deep shift register plus match/parity decode, outputting `match`, `valid`, `f`, `v`, `h`.
- **Top level:** counters, FSM, flag registers.

## Test plan

- **Reset behaviour:** reset asserted mid-stream → `o_fvht`=0110, `o_locked`=0, `o_err_count`=0, `o_vdat_colour`=0 immediately.
- **Single valid TRS:** input 3FF,000,000,XYZ=10'h274 (F=0,V=0,H=1) → T high for 4 cycles starting at edge n+4. `o_fvht[1]` is still 1 (SEARCH forces). Data is delayed exactly 4.
- **Lock acquisition:** 4 valid TRS spaced 1000 words apart → `o_locked` rises after the 4th. A subsequent SAV XYZ=10'h200 (F=V=H=0) → `o_fvht`=0000 from the first 000 output word.
- **Protection error:** XYZ=10'h27C while LOCKED → one `o_trs_err` pulse, `o_err_count` +1, `o_locked` falls, F/V/H unchanged. 300 bad TRS → count sticks at 255.
- **Gap timeout:** LOCKED with no TRS for 4400 words → `o_locked`=0 and `o_fvht[2:1]`=11. A valid TRS landing exactly on word 4400 keeps lock.
- **Not a TRS:** 3FF,000,000,10'h074 → no T flag, no error, no state change.
